// File: rtl/iq_issue_ctrl.sv
// Issue-side controller for one issue queue: writeback wakeup, oldest-ready
// selection into a registered issue slot, dispatch allocation and occupancy.
module iq_issue_ctrl #(
  parameter int IQ_DEPTH = 8,
  parameter int PREG_W   = 6,
  parameter int ROB_LOG  = 6,
  localparam int IDX_W   = $clog2(IQ_DEPTH),
  localparam int CNT_W   = IDX_W + 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [IQ_DEPTH-1:0]          entry_valid,
  input  logic [IQ_DEPTH-1:0]          entry_ready_to_go,
  input  logic [IQ_DEPTH-1:0]          entry_src1_is_reg,
  input  logic [IQ_DEPTH-1:0]          entry_src2_is_reg,
  input  logic [IQ_DEPTH*PREG_W-1:0]   entry_prs1,
  input  logic [IQ_DEPTH*PREG_W-1:0]   entry_prs2,
  input  logic [IQ_DEPTH-1:0]          entry_robidx_flag,
  input  logic [IQ_DEPTH*ROB_LOG-1:0]  entry_robidx,
  input  logic                         wb_valid,
  input  logic [PREG_W-1:0]            wb_prd,
  output logic [IQ_DEPTH-1:0]          wakeup_src1,
  output logic [IQ_DEPTH-1:0]          wakeup_src2,
  input  logic                         enq_req,
  output logic                         enq_grant,
  output logic [IQ_DEPTH-1:0]          enq_onehot,
  output logic                         iq_full,
  output logic [CNT_W-1:0]             iq_count,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [IDX_W-1:0]             issue_idx,
  output logic [IQ_DEPTH-1:0]          issuing
);

  logic                r_issue_valid;
  logic [IDX_W-1:0]    r_issue_idx;
  logic [CNT_W-1:0]    r_count;

  logic                w_wb_live;
  logic [IQ_DEPTH-1:0] w_slot_oh;
  logic [IQ_DEPTH-1:0] w_cand;
  logic                w_found;
  logic [IDX_W-1:0]    w_sel;
  logic                w_best_flag;
  logic [ROB_LOG-1:0]  w_best_rob;
  logic [IQ_DEPTH-1:0] w_free_oh;
  logic                w_accept;
  logic                w_inc;
  logic                w_dec;

  // Physical register 0 is the hardwired zero register and never produces a wakeup.
  assign w_wb_live = wb_valid & (wb_prd != '0);

  always_comb begin
    wakeup_src1 = '0;
    wakeup_src2 = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      wakeup_src1[i] = w_wb_live & entry_valid[i] & entry_src1_is_reg[i] &
                       (entry_prs1[i*PREG_W +: PREG_W] == wb_prd);
      wakeup_src2[i] = w_wb_live & entry_valid[i] & entry_src2_is_reg[i] &
                       (entry_prs2[i*PREG_W +: PREG_W] == wb_prd);
    end
  end

  function automatic logic older(input logic fa, input logic [ROB_LOG-1:0] ra,
                                 input logic fb, input logic [ROB_LOG-1:0] rb);
    return (fa == fb) ? (ra < rb) : (ra > rb);
  endfunction

  always_comb begin
    w_slot_oh = '0;
    w_slot_oh[r_issue_idx] = r_issue_valid;
  end

  assign w_accept = r_issue_valid & issue_ready;
  assign issuing  = (w_accept & ~flush) ? w_slot_oh : '0;
  assign w_cand   = entry_valid & entry_ready_to_go & ~w_slot_oh & ~issuing;

  // Ascending scan with strict "older" keeps the lower index on equal age.
  always_comb begin
    w_found     = 1'b0;
    w_sel       = '0;
    w_best_flag = 1'b0;
    w_best_rob  = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (w_cand[i] && (!w_found ||
          older(entry_robidx_flag[i], entry_robidx[i*ROB_LOG +: ROB_LOG],
                w_best_flag, w_best_rob))) begin
        w_found     = 1'b1;
        w_sel       = IDX_W'(i);
        w_best_flag = entry_robidx_flag[i];
        w_best_rob  = entry_robidx[i*ROB_LOG +: ROB_LOG];
      end
    end
  end

  always_comb begin
    w_free_oh = '0;
    for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
      if (!entry_valid[i]) begin
        w_free_oh    = '0;
        w_free_oh[i] = 1'b1;
      end
    end
  end

  assign iq_full    = &entry_valid;
  assign enq_grant  = ~iq_full & ~flush;
  assign enq_onehot = (enq_req & ~flush) ? w_free_oh : '0;

  assign w_inc = enq_req & enq_grant;
  assign w_dec = |issuing;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_issue_valid <= 1'b0;
      r_issue_idx   <= '0;
      r_count       <= '0;
    end else if (flush) begin
      r_issue_valid <= 1'b0;
      r_count       <= '0;
    end else begin
      // No preemption: a held selection only moves on acceptance.
      if (!r_issue_valid || w_accept) begin
        r_issue_valid <= w_found;
        if (w_found) r_issue_idx <= w_sel;
      end
      if (w_inc && !w_dec && r_count != CNT_W'(IQ_DEPTH)) r_count <= r_count + 1'b1;
      else if (w_dec && !w_inc && r_count != '0)          r_count <= r_count - 1'b1;
    end
  end

  assign issue_valid = r_issue_valid;
  assign issue_idx   = r_issue_idx;
  assign iq_count    = r_count;

endmodule

// File: tb/tb_iq_issue_ctrl.sv
// Directed bench for iq_issue_ctrl; the bench plays the role of the entries,
// retiring an entry's valid bit the cycle after its issuing pulse.
module tb_iq_issue_ctrl;
  localparam int D = 8;
  localparam int P = 6;
  localparam int R = 6;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         flush;
  logic [D-1:0] entry_valid, entry_ready_to_go, entry_src1_is_reg, entry_src2_is_reg;
  logic [D*P-1:0] entry_prs1, entry_prs2;
  logic [D-1:0] entry_robidx_flag;
  logic [D*R-1:0] entry_robidx;
  logic         wb_valid;
  logic [P-1:0] wb_prd;
  logic [D-1:0] wakeup_src1, wakeup_src2;
  logic         enq_req, enq_grant;
  logic [D-1:0] enq_onehot;
  logic         iq_full;
  logic [3:0]   iq_count;
  logic         issue_valid, issue_ready;
  logic [2:0]   issue_idx;
  logic [D-1:0] issuing;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  iq_issue_ctrl #(.IQ_DEPTH(D), .PREG_W(P), .ROB_LOG(R)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .entry_valid(entry_valid), .entry_ready_to_go(entry_ready_to_go),
    .entry_src1_is_reg(entry_src1_is_reg), .entry_src2_is_reg(entry_src2_is_reg),
    .entry_prs1(entry_prs1), .entry_prs2(entry_prs2),
    .entry_robidx_flag(entry_robidx_flag), .entry_robidx(entry_robidx),
    .wb_valid(wb_valid), .wb_prd(wb_prd),
    .wakeup_src1(wakeup_src1), .wakeup_src2(wakeup_src2),
    .enq_req(enq_req), .enq_grant(enq_grant), .enq_onehot(enq_onehot),
    .iq_full(iq_full), .iq_count(iq_count),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_idx(issue_idx), .issuing(issuing)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_all();
    flush = 0; entry_valid = '0; entry_ready_to_go = '0;
    entry_src1_is_reg = '0; entry_src2_is_reg = '0;
    entry_prs1 = '0; entry_prs2 = '0; entry_robidx_flag = '0; entry_robidx = '0;
    wb_valid = 0; wb_prd = '0; enq_req = 0; issue_ready = 0;
  endtask

  task automatic set_entry(input int i, input logic v, input logic r,
                           input logic f, input logic [R-1:0] rob);
    entry_valid[i] = v;
    entry_ready_to_go[i] = r;
    entry_robidx_flag[i] = f;
    entry_robidx[i*R +: R] = rob;
  endtask

  task automatic test_reset();
    clear_all();
    reset_n = 0;
    entry_valid = 8'hFF; entry_ready_to_go = 8'hFF; issue_ready = 1;
    #1;
    if (issue_valid !== 1'b0) begin $display("FAIL reset_issue_valid: got %b want 0", issue_valid); tests_failed++; end
    tests_run++;
    tick(); tick();
    if (issuing !== 8'h00) begin $display("FAIL reset_issuing: got %h want 00", issuing); tests_failed++; end
    tests_run++;
    if (iq_count !== 4'd0) begin $display("FAIL reset_count: got %0d want 0", iq_count); tests_failed++; end
    tests_run++;
    if (issue_idx !== 3'd0) begin $display("FAIL reset_idx: got %0d want 0", issue_idx); tests_failed++; end
    tests_run++;
    clear_all();
    #1;
    if (enq_grant !== 1'b1) begin $display("FAIL reset_grant: got %b want 1", enq_grant); tests_failed++; end
    tests_run++;
    reset_n = 1;
    tick();
  endtask

  task automatic test_wakeup();
    clear_all();
    set_entry(3, 1, 0, 0, 6'd0);
    entry_src1_is_reg[3] = 1; entry_src2_is_reg[3] = 1;
    entry_prs1[3*P +: P] = 6'd5; entry_prs2[3*P +: P] = 6'd7;
    wb_valid = 1; wb_prd = 6'd5;
    #1;
    if (wakeup_src1 !== 8'h08) begin $display("FAIL wake_src1: got %h want 08", wakeup_src1); tests_failed++; end
    tests_run++;
    if (wakeup_src2 !== 8'h00) begin $display("FAIL wake_src2_quiet: got %h want 00", wakeup_src2); tests_failed++; end
    tests_run++;
    wb_prd = 6'd7;
    #1;
    if (wakeup_src2 !== 8'h08 || wakeup_src1 !== 8'h00) begin
      $display("FAIL wake_src2: got src1=%h src2=%h want 00/08", wakeup_src1, wakeup_src2); tests_failed++;
    end
    tests_run++;
    wb_valid = 0; wb_prd = 6'd5;
    #1;
    if (wakeup_src1 !== 8'h00) begin $display("FAIL wake_no_valid: got %h want 00", wakeup_src1); tests_failed++; end
    tests_run++;
    wb_valid = 1; wb_prd = 6'd0; entry_prs1[3*P +: P] = 6'd0;
    #1;
    if (wakeup_src1 !== 8'h00) begin $display("FAIL wake_preg0: got %h want 00", wakeup_src1); tests_failed++; end
    tests_run++;
    clear_all();
    tick();
  endtask

  task automatic test_age_wrap();
    clear_all();
    set_entry(1, 1, 1, 1'b1, 6'd2);
    set_entry(6, 1, 1, 1'b0, 6'd60);
    #1;
    if (issue_valid !== 1'b0) begin $display("FAIL age_latency: got %b want 0", issue_valid); tests_failed++; end
    tests_run++;
    tick();
    if (issue_valid !== 1'b1 || issue_idx !== 3'd6) begin
      $display("FAIL age_first: got v=%b idx=%0d want 1/6", issue_valid, issue_idx); tests_failed++;
    end
    tests_run++;
    issue_ready = 1;
    #1;
    if (issuing !== 8'h40) begin $display("FAIL age_pulse6: got %h want 40", issuing); tests_failed++; end
    tests_run++;
    tick();
    set_entry(6, 0, 0, 0, 6'd0);
    if (issue_valid !== 1'b1 || issue_idx !== 3'd1) begin
      $display("FAIL age_second: got v=%b idx=%0d want 1/1", issue_valid, issue_idx); tests_failed++;
    end
    tests_run++;
    if (issuing !== 8'h02) begin $display("FAIL age_pulse1: got %h want 02", issuing); tests_failed++; end
    tests_run++;
    tick();
    set_entry(1, 0, 0, 0, 6'd0);
    if (issue_valid !== 1'b0) begin $display("FAIL age_drain: got %b want 0", issue_valid); tests_failed++; end
    tests_run++;
    if (iq_count !== 4'd0) begin $display("FAIL age_count_floor: got %0d want 0", iq_count); tests_failed++; end
    tests_run++;
    clear_all();
    tick();
  endtask

  task automatic test_backpressure();
    clear_all();
    set_entry(4, 1, 1, 0, 6'd30);
    tick();
    set_entry(2, 1, 1, 0, 6'd10);
    for (int c = 0; c < 5; c++) begin
      if (issue_valid !== 1'b1 || issue_idx !== 3'd4 || issuing !== 8'h00) begin
        $display("FAIL bp_hold[%0d]: got v=%b idx=%0d iss=%h want 1/4/00", c, issue_valid, issue_idx, issuing);
        tests_failed++;
      end
      tests_run++;
      tick();
    end
    issue_ready = 1;
    #1;
    if (issuing !== 8'h10) begin $display("FAIL bp_release: got %h want 10", issuing); tests_failed++; end
    tests_run++;
    tick();
    set_entry(4, 0, 0, 0, 6'd0);
    if (issue_idx !== 3'd2 || issuing !== 8'h04) begin
      $display("FAIL bp_next: got idx=%0d iss=%h want 2/04", issue_idx, issuing); tests_failed++;
    end
    tests_run++;
    tick();
    set_entry(2, 0, 0, 0, 6'd0);
    clear_all();
    tick();
  endtask

  task automatic test_alloc_full();
    clear_all();
    if (iq_count !== 4'd0) begin $display("FAIL alloc_start_count: got %0d want 0", iq_count); tests_failed++; end
    tests_run++;
    entry_valid = 8'b1111_0111; enq_req = 1;
    #1;
    if (enq_onehot !== 8'h08 || enq_grant !== 1'b1 || iq_full !== 1'b0) begin
      $display("FAIL alloc_onehot: got oh=%h g=%b f=%b want 08/1/0", enq_onehot, enq_grant, iq_full); tests_failed++;
    end
    tests_run++;
    tick();
    if (iq_count !== 4'd1) begin $display("FAIL alloc_count_inc: got %0d want 1", iq_count); tests_failed++; end
    tests_run++;
    entry_valid = 8'hFF;
    #1;
    if (enq_grant !== 1'b0 || iq_full !== 1'b1 || enq_onehot !== 8'h00) begin
      $display("FAIL alloc_full: got g=%b f=%b oh=%h want 0/1/00", enq_grant, iq_full, enq_onehot); tests_failed++;
    end
    tests_run++;
    tick();
    if (iq_count !== 4'd1) begin $display("FAIL alloc_full_count: got %0d want 1", iq_count); tests_failed++; end
    tests_run++;
    entry_valid = 8'b1111_0111; enq_req = 0;
    set_entry(0, 1, 1, 0, 6'd5);
    tick();
    issue_ready = 1; enq_req = 1;
    #1;
    if (issuing !== 8'h01 || enq_onehot !== 8'h08) begin
      $display("FAIL alloc_both: got iss=%h oh=%h want 01/08", issuing, enq_onehot); tests_failed++;
    end
    tests_run++;
    tick();
    issue_ready = 0; enq_req = 0; entry_valid = 8'hFE; entry_ready_to_go = '0;
    if (iq_count !== 4'd1 || issue_valid !== 1'b0) begin
      $display("FAIL alloc_net_zero: got cnt=%0d v=%b want 1/0", iq_count, issue_valid); tests_failed++;
    end
    tests_run++;
    enq_req = 1;
    tick();
    if (iq_count !== 4'd2) begin $display("FAIL alloc_count2: got %0d want 2", iq_count); tests_failed++; end
    tests_run++;
    entry_valid = '0;
    for (int c = 0; c < 10; c++) tick();
    if (iq_count !== 4'd8) begin $display("FAIL alloc_count_sat: got %0d want 8", iq_count); tests_failed++; end
    tests_run++;
    enq_req = 0;
  endtask

  task automatic test_flush();
    clear_all();
    set_entry(5, 1, 1, 0, 6'd1);
    entry_src1_is_reg[5] = 1; entry_prs1[5*P +: P] = 6'd9;
    enq_req = 1;
    tick();
    if (issue_valid !== 1'b1 || issue_idx !== 3'd5) begin
      $display("FAIL flush_setup: got v=%b idx=%0d want 1/5", issue_valid, issue_idx); tests_failed++;
    end
    tests_run++;
    issue_ready = 1; flush = 1; wb_valid = 1; wb_prd = 6'd9;
    #1;
    if (issuing !== 8'h00 || enq_onehot !== 8'h00 || enq_grant !== 1'b0) begin
      $display("FAIL flush_suppress: got iss=%h oh=%h g=%b want 00/00/0", issuing, enq_onehot, enq_grant); tests_failed++;
    end
    tests_run++;
    if (wakeup_src1 !== 8'h20) begin $display("FAIL flush_wakeup: got %h want 20", wakeup_src1); tests_failed++; end
    tests_run++;
    tick();
    flush = 0; issue_ready = 0; wb_valid = 0;
    if (issue_valid !== 1'b0 || iq_count !== 4'd0) begin
      $display("FAIL flush_clear: got v=%b cnt=%0d want 0/0", issue_valid, iq_count); tests_failed++;
    end
    tests_run++;
    tick();
    enq_req = 0;
    if (issue_valid !== 1'b1 || issue_idx !== 3'd5 || iq_count !== 4'd1) begin
      $display("FAIL flush_reload: got v=%b idx=%0d cnt=%0d want 1/5/1", issue_valid, issue_idx, iq_count); tests_failed++;
    end
    tests_run++;
  endtask

  task automatic test_reset_mid();
    issue_ready = 1;
    #2;
    reset_n = 0;
    #1;
    if (issue_valid !== 1'b0 || issuing !== 8'h00 || iq_count !== 4'd0 || issue_idx !== 3'd0) begin
      $display("FAIL reset_mid: got v=%b iss=%h cnt=%0d idx=%0d want 0/00/0/0",
               issue_valid, issuing, iq_count, issue_idx);
      tests_failed++;
    end
    tests_run++;
    tick();
    if (issuing !== 8'h00) begin $display("FAIL reset_mid_hold: got %h want 00", issuing); tests_failed++; end
    tests_run++;
    clear_all();
    reset_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_wakeup();
    test_age_wrap();
    test_backpressure();
    test_alloc_full();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
